// File: rtl/icache_fill_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : icache_fill_ctrl_if
//  Brief    : Fetch / cache / main-memory signal bundle for icache_fill_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
interface icache_fill_ctrl_if;
    // fetch stage
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic [15:0] instr;
    logic        instr_vld;
    logic        stall;
    // instruction cache
    logic [13:0] cache_addr;
    logic        cache_re;
    logic        cache_we;
    logic [63:0] cache_wr_data;
    logic        cache_wdirty;
    logic        cache_hit;
    logic [63:0] cache_rd_data;
    // main memory
    logic        mem_re;
    logic [13:0] mem_addr;
    logic [63:0] mem_rd_data;
    // performance monitor
    logic [15:0] miss_cnt;

    // controller side
    modport master (
        input  fetch_req, fetch_addr, cache_hit, cache_rd_data, mem_rd_data,
        output instr, instr_vld, stall, cache_addr, cache_re, cache_we,
               cache_wr_data, cache_wdirty, mem_re, mem_addr, miss_cnt
    );

    // fetch stage, cache array and memory side
    modport slave (
        output fetch_req, fetch_addr, cache_hit, cache_rd_data, mem_rd_data,
        input  instr, instr_vld, stall, cache_addr, cache_re, cache_we,
               cache_wr_data, cache_wdirty, mem_re, mem_addr, miss_cnt
    );
endinterface
`default_nettype wire

// File: rtl/icache_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : icache_fill_ctrl
//  Brief    : Direct-mapped I-cache lookup with fixed-latency line fill and
//             saturating miss counter.
//  Revision : 1.0 - initial release
// ============================================================================
module icache_fill_ctrl #(
    parameter int MEM_LAT = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    icache_fill_ctrl_if.master bus
);

    localparam int                 CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [15:0]        CNT_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_FILL = 2'd2
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [13:0]        line_q;
    logic [1:0]         word_q;
    logic [63:0]        fill_q;
    logic [15:0]        miss_cnt_q;

    logic               w_miss;
    logic [15:0]        w_instr;
    logic               w_instr_vld;
    logic               w_stall;
    logic [13:0]        w_cache_addr;
    logic               w_cache_re;
    logic               w_cache_we;
    logic               w_mem_re;

    function automatic logic [15:0] sel_word(input logic [63:0] line,
                                             input logic [1:0]  k);
        return line[{k, 4'b0000} +: 16];
    endfunction

    assign w_miss = (state_q == ST_IDLE) && bus.fetch_req && !bus.cache_hit;

    // Only the latched line/word are used once a fill starts, so fetch-side
    // protocol violations during a stall cannot corrupt it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            line_q     <= '0;
            word_q     <= '0;
            fill_q     <= '0;
            miss_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_miss) begin
                        state_q <= ST_MEM;
                        line_q  <= bus.fetch_addr[15:2];
                        word_q  <= bus.fetch_addr[1:0];
                        cnt_q   <= CNT_LOAD;
                        if (miss_cnt_q != CNT_MAX) begin
                            miss_cnt_q <= miss_cnt_q + 16'd1;
                        end
                    end
                end
                ST_MEM: begin
                    if (cnt_q == '0) begin
                        fill_q  <= bus.mem_rd_data;
                        state_q <= ST_FILL;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_FILL: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes are decoded from state and forced low while reset is held so
    // that a reset mid-fill never produces a write or memory request.
    always_comb begin
        w_instr      = 16'h0000;
        w_instr_vld  = 1'b0;
        w_stall      = 1'b0;
        w_cache_addr = line_q;
        w_cache_re   = 1'b0;
        w_cache_we   = 1'b0;
        w_mem_re     = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    w_cache_addr = bus.fetch_addr[15:2];
                    w_cache_re   = bus.fetch_req;
                    if (bus.fetch_req) begin
                        if (bus.cache_hit) begin
                            w_instr     = sel_word(bus.cache_rd_data, bus.fetch_addr[1:0]);
                            w_instr_vld = 1'b1;
                        end else begin
                            w_stall = 1'b1;
                        end
                    end
                end
                ST_MEM: begin
                    w_mem_re = 1'b1;
                    w_stall  = 1'b1;
                end
                ST_FILL: begin
                    w_cache_we  = 1'b1;
                    w_instr     = sel_word(fill_q, word_q);
                    w_instr_vld = 1'b1;
                end
                default: begin
                    w_stall = 1'b0;
                end
            endcase
        end
    end

    assign bus.instr         = w_instr;
    assign bus.instr_vld     = w_instr_vld;
    assign bus.stall         = w_stall;
    assign bus.cache_addr    = w_cache_addr;
    assign bus.cache_re      = w_cache_re;
    assign bus.cache_we      = w_cache_we;
    assign bus.cache_wr_data = fill_q;
    assign bus.cache_wdirty  = 1'b0;
    assign bus.mem_re        = w_mem_re;
    assign bus.mem_addr      = line_q;
    assign bus.miss_cnt      = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_fill_ctrl
//  Brief    : Directed bench for icache_fill_ctrl with a cycle-count model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icache_fill_ctrl;

    localparam int MEM_LAT = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_pass = 0;
    int   n_chk  = 0;

    always #5 clk = ~clk;

    icache_fill_ctrl_if bus();

    icache_fill_ctrl #(.MEM_LAT(MEM_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] wsel(input logic [63:0] l, input int k);
        logic [63:0] s;
        s = l >> (16 * k);
        return s[15:0];
    endfunction

    // Model: a miss occupies the MEM_LAT+1 cycles following the request;
    // m_k counts those cycles (1..MEM_LAT memory, MEM_LAT+1 fill).
    logic        m_busy = 1'b0;
    int          m_k    = 0;
    logic [13:0] m_line = '0;
    int          m_word = 0;
    logic [63:0] m_buf  = '0;
    logic [15:0] m_cnt  = '0;

    logic        e_vld, e_stall, e_re, e_we, e_mre;
    logic [15:0] e_instr;
    logic [13:0] e_caddr;

    always @(negedge clk) begin
        e_vld = 1'b0; e_stall = 1'b0; e_re = 1'b0; e_we = 1'b0; e_mre = 1'b0;
        e_instr = 16'h0000; e_caddr = m_line;
        if (!rst) begin
            if (!m_busy) begin
                e_caddr = bus.fetch_addr[15:2];
                e_re    = bus.fetch_req;
                if (bus.fetch_req && bus.cache_hit) begin
                    e_vld   = 1'b1;
                    e_instr = wsel(bus.cache_rd_data, int'(bus.fetch_addr[1:0]));
                end else if (bus.fetch_req) begin
                    e_stall = 1'b1;
                end
            end else if (m_k <= MEM_LAT) begin
                e_mre   = 1'b1;
                e_stall = 1'b1;
            end else begin
                e_we    = 1'b1;
                e_vld   = 1'b1;
                e_instr = wsel(m_buf, m_word);
            end
        end
        chk("instr_vld", 64'(bus.instr_vld), 64'(e_vld));
        chk("stall", 64'(bus.stall), 64'(e_stall));
        chk("cache_re", 64'(bus.cache_re), 64'(e_re));
        chk("cache_we", 64'(bus.cache_we), 64'(e_we));
        chk("mem_re", 64'(bus.mem_re), 64'(e_mre));
        chk("cache_wdirty", 64'(bus.cache_wdirty), 64'd0);
        chk("miss_cnt", 64'(bus.miss_cnt), 64'(m_cnt));
        if (!rst) chk("cache_addr", 64'(bus.cache_addr), 64'(e_caddr));
        if (e_vld || rst) chk("instr", 64'(bus.instr), 64'(e_instr));
        if (e_mre) chk("mem_addr", 64'(bus.mem_addr), 64'(m_line));
        if (e_we) chk("cache_wr_data", bus.cache_wr_data, m_buf);

        // effect of the coming rising edge
        if (rst) begin
            m_busy = 1'b0; m_k = 0; m_buf = '0; m_cnt = '0;
        end else if (!m_busy) begin
            if (bus.fetch_req && !bus.cache_hit) begin
                m_busy = 1'b1;
                m_k    = 1;
                m_line = bus.fetch_addr[15:2];
                m_word = int'(bus.fetch_addr[1:0]);
                if (m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
        end else begin
            if (m_k == MEM_LAT) m_buf = bus.mem_rd_data;
            if (m_k == MEM_LAT + 1) m_busy = 1'b0;
            else m_k = m_k + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic req(input logic [15:0] a, input logic h,
                       input logic [63:0] rd, input logic [63:0] md);
        bus.fetch_req     = 1'b1;
        bus.fetch_addr    = a;
        bus.cache_hit     = h;
        bus.cache_rd_data = rd;
        bus.mem_rd_data   = md;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.fetch_req = 1'b0; bus.fetch_addr = '0; bus.cache_hit = 1'b0;
        bus.cache_rd_data = '0; bus.mem_rd_data = '0;
        tick();
        look();
        chk("rst_miss_cnt", 64'(bus.miss_cnt), 64'd0);
        chk("rst_instr_vld", 64'(bus.instr_vld), 64'd0);
        tick();
        rst = 1'b0;

        // hit, zero latency
        req(16'h0010, 1'b1, 64'h4444_3333_2222_1111, 64'd0);
        look();
        chk("hit_instr", 64'(bus.instr), 64'h1111);
        chk("hit_vld", 64'(bus.instr_vld), 64'd1);
        chk("hit_stall", 64'(bus.stall), 64'd0);
        tick();

        // miss at 0x0123, word 3 of the line
        req(16'h0123, 1'b0, 64'd0, 64'hDDDD_CCCC_BBBB_AAAA);
        look();
        chk("miss_stall", 64'(bus.stall), 64'd1);
        for (int c = 1; c <= MEM_LAT; c++) begin
            tick(); look();
            chk("miss_mem_re", 64'(bus.mem_re), 64'd1);
            chk("miss_mem_addr", 64'(bus.mem_addr), 64'h048);
        end
        tick(); look();
        chk("fill_we", 64'(bus.cache_we), 64'd1);
        chk("fill_addr", 64'(bus.cache_addr), 64'h048);
        chk("fill_instr", 64'(bus.instr), 64'hDDDD);
        chk("fill_vld", 64'(bus.instr_vld), 64'd1);
        chk("fill_miss_cnt", 64'(bus.miss_cnt), 64'd1);
        tick();
        bus.fetch_req = 1'b0;
        look();
        chk("model_cnt_1", 64'(m_cnt), 64'd1);
        tick();

        // miss with fetch_req dropped in cycle 2
        req(16'h0200, 1'b0, 64'd0, 64'h1234_5678_9ABC_DEF0);
        tick();
        tick();
        bus.fetch_req = 1'b0;
        tick(); tick(); tick(); look();
        chk("drop_we", 64'(bus.cache_we), 64'd1);
        chk("drop_instr", 64'(bus.instr), 64'hDEF0);
        for (int c = 0; c < 3; c++) begin
            tick(); look();
            chk("drop_no_mem_re", 64'(bus.mem_re), 64'd0);
        end
        tick();

        // reset in cycle 3 of a miss
        req(16'h0444, 1'b0, 64'd0, 64'hFFFF_EEEE_DDDD_CCCC);
        tick(); tick(); tick();
        rst = 1'b1;
        bus.fetch_req = 1'b0;
        look();
        chk("rstmid_mem_re", 64'(bus.mem_re), 64'd0);
        tick();
        rst = 1'b0;
        look();
        chk("rstmid_miss_cnt", 64'(bus.miss_cnt), 64'd0);
        for (int c = 0; c < 5; c++) begin
            tick(); look();
            chk("rstmid_no_we", 64'(bus.cache_we), 64'd0);
        end
        tick();

        // saturation: start from 0xFFFE, three misses
        force dut.miss_cnt_q = 16'hFFFE;
        m_cnt = 16'hFFFE;
        #1;
        release dut.miss_cnt_q;
        look();
        chk("sat_start", 64'(bus.miss_cnt), 64'hFFFE);
        for (int i = 0; i < 3; i++) begin
            tick();
            req(16'h0800 + 16'(i * 4), 1'b0, 64'd0, 64'(i) * 64'h0101);
            for (int c = 0; c <= MEM_LAT; c++) tick();
            bus.fetch_req = 1'b0;
            look();
            chk("sat_cnt", 64'(bus.miss_cnt), 64'hFFFF);
        end
        tick();
        look();
        chk("model_cnt_sat", 64'(m_cnt), 64'hFFFF);
        tick();

        // hit, miss, hit to line 0x0C0 word 1
        req(16'h0301, 1'b1, 64'h0A0A_0B0B_0C0C_0D0D, 64'd0);
        look();
        chk("hmh_hit1", 64'(bus.instr), 64'h0C0C);
        tick();
        req(16'h0301, 1'b0, 64'd0, 64'h7777_6666_5555_4444);
        for (int c = 0; c <= MEM_LAT; c++) tick();
        look();
        chk("hmh_fill", 64'(bus.instr), 64'h5555);
        tick();
        req(16'h0301, 1'b1, 64'h7777_6666_5555_4444, 64'd0);
        look();
        chk("hmh_hit2_instr", 64'(bus.instr), 64'h5555);
        chk("hmh_hit2_vld", 64'(bus.instr_vld), 64'd1);
        chk("hmh_hit2_stall", 64'(bus.stall), 64'd0);
        tick();
        bus.fetch_req = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_fill_ctrl.md
# icache_fill_ctrl

Fetch-side controller between the fetch stage and the direct-mapped instruction cache. Each cycle it presents the fetch address to the cache and returns the selected 16-bit instruction on a hit. On a miss it stalls fetch, reads the 64-bit line from main memory (fixed latency), writes it into the cache clean, and forwards the requested word from the fill buffer. It also keeps a saturating miss counter for performance monitoring.

## Interface
- MEM_LAT, 4, main-memory read latency in cycles (≥1)
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- fetch_req  in  1  fetch stage requests an instruction this cycle
- fetch_addr  in  16  word address of instruction; [15:2] line address, [1:0] word within line
- instr  out  16  instruction word
- instr_vld  out  1  instr valid this cycle
- stall  out  1  fetch must hold fetch_addr/fetch_req and not advance
- cache_addr  out  14  line address to cache
- cache_re  out  1  cache read enable
- cache_we  out  1  cache line write enable
- cache_wr_data  out  64  line to write
- cache_wdirty  out  1  dirty bit to write; always 0
- cache_hit  in  1  tag match and valid for cache_addr
- cache_rd_data  in  64  line read from cache
- mem_re  out  1  main-memory read request
- mem_addr  out  14  line address to memory
- mem_rd_data  in  64  line from memory, valid in last cycle of request
- miss_cnt  out  16  saturating count of misses

## Operation
- Word select: word k = line[16k+15:16k], k = addr[1:0] (word 0 in bits 15:0).
- States: IDLE, MEM, FILL. Reset → IDLE.
- IDLE: cache_addr = fetch_addr[15:2]; cache_re = fetch_req.
  - fetch_req & cache_hit: instr = selected word of cache_rd_data; instr_vld = 1; stall = 0; stay IDLE.
  - fetch_req & ~cache_hit: stall = 1, instr_vld = 0; latch line address and word index; load counter = MEM_LAT-1; miss_cnt += 1 (saturates at 0xFFFF); → MEM.
  - ~fetch_req: all strobes 0; stay IDLE.
- MEM: mem_re = 1, mem_addr = latched line; cache_addr = latched line; cache_re = 0; stall = 1. Counter decrements each cycle. When counter == 0, capture mem_rd_data into fill buffer → FILL.
- FILL (one cycle): cache_we = 1, cache_wr_data = fill buffer, cache_wdirty = 0, cache_addr = latched line; instr = latched word of fill buffer; instr_vld = 1; stall = 0; → IDLE.
- Fill always completes once started, even if fetch_req drops; instr_vld is still asserted in FILL.
- fetch_addr changes while stall = 1 are a protocol violation. The controller uses only latched values in MEM/FILL, so a violation cannot corrupt the fill.
- mem_re is never asserted in IDLE or FILL; cache_re and cache_we are never asserted together.

## Timing
- Hit: zero added latency. instr_vld is asserted in the request cycle; cache_hit and cache_rd_data are treated as same-cycle.
- Miss: the request is cycle 0. mem_re is high in cycles 1..MEM_LAT. FILL is cycle MEM_LAT+1, with instr_vld = 1 and cache_we = 1. The next request is looked up in cycle MEM_LAT+2. For MEM_LAT = 4, instr arrives at cycle 5.
- Back-to-back misses: each costs MEM_LAT+2 cycles from request to next lookup.
- Reset values, applied at the first edge with rst = 1: state IDLE; counter 0; fill buffer 0; miss_cnt 0; instr 0 and instr_vld 0 (combinational from state); mem_re, cache_we, cache_re, stall all 0 while rst is high.
- Reset mid-MEM or mid-FILL: state returns to IDLE at the next edge. No cache_we occurs after the reset edge, and the partially fetched line is discarded.
- miss_cnt holds at 0xFFFF; further misses do not wrap.

## Test plan
- Reset, then fetch_req = 1, fetch_addr = 0x0010, cache_hit = 1, cache_rd_data = 0x4444_3333_2222_1111 → same cycle: instr = 0x1111, instr_vld = 1, stall = 0, mem_re = 0.
- Miss at fetch_addr = 0x0123 with MEM_LAT = 4 and mem_rd_data = 0xDDDD_CCCC_BBBB_AAAA:
  - mem_re high for cycles 1–4 with mem_addr = 0x048.
  - Cycle 5: cache_we = 1, cache_addr = 0x048, cache_wdirty = 0, instr = 0xDDDD, instr_vld = 1.
  - miss_cnt = 1.
- Miss, then fetch_req drops in cycle 2 → fill still completes in cycle 5 with cache_we = 1; no extra mem_re afterwards.
- rst asserted in cycle 3 of a miss → IDLE next cycle; cache_we never asserted; mem_re = 0; miss_cnt = 0.
- Force miss_cnt to 0xFFFE, then issue three misses → miss_cnt reads 0xFFFF and stays there.
- Hit, miss, hit to the same line → second hit has zero latency, and instr matches the previously filled word.
